// File: rtl/vga_pkg.sv
// Shared definitions for the VGA double-buffered framebuffer: writer states
// and the memory map agreed between the frame writer and the address decoder.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITE     = 2'd1,
    WAIT_SWAP = 2'd2
  } vga_fw_state_t;

  localparam int          VGA_IMG_W = 256;
  localparam int          VGA_IMG_H = 256;
  localparam logic [31:0] VGA_BASE0 = 32'h0000_0000;
  localparam logic [31:0] VGA_BASE1 = 32'h0001_0000;

endpackage

// File: rtl/vga_xy_counter.sv
// Raster position tracker: x/y pixel coordinates plus a running linear offset
// (y*IMG_W + x) kept by increment so no multiplier is needed.
module vga_xy_counter
  import vga_pkg::*;
#(
  parameter int IMG_W = VGA_IMG_W,
  parameter int IMG_H = VGA_IMG_H
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        inc,
  output logic        last_pixel,
  output logic [31:0] offset
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

  logic [XW-1:0] x;
  logic [YW-1:0] y;

  assign last_pixel = (x == X_MAX) && (y == Y_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x      <= '0;
      y      <= '0;
      offset <= '0;
    end else if (clear) begin
      x      <= '0;
      y      <= '0;
      offset <= '0;
    end else if (inc) begin
      offset <= offset + 32'd1;
      if (x == X_MAX) begin
        x <= '0;
        y <= (y == Y_MAX) ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

endmodule

// File: rtl/vga_frame_writer.sv
// Producer side of the VGA double buffer: streams one frame of pixels into the
// back image and swaps the displayed image at the following vertical blank.
module vga_frame_writer
  import vga_pkg::*;
#(
  parameter int          IMG_W = VGA_IMG_W,
  parameter int          IMG_H = VGA_IMG_H,
  parameter logic [31:0] BASE0 = VGA_BASE0,
  parameter logic [31:0] BASE1 = VGA_BASE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        vblank,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  output logic        image_select,
  output logic        busy,
  output logic        frame_done
);

  vga_fw_state_t state;
  logic          last_accepted;
  logic          accept;
  logic          clear;
  logic          last_pixel;
  logic [31:0]   offset;

  // A new pixel may only be taken when the write slot is free or being freed
  // this cycle, which gives back-to-back writes under continuous ack.
  assign pix_ready = (state == WRITE) && !last_accepted && (!mem_we || mem_ack);
  assign accept    = pix_valid && pix_ready;
  assign clear     = (state == IDLE) && start;
  assign busy      = (state == WRITE) || (state == WAIT_SWAP);

  vga_xy_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_xy (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .inc        (accept),
    .last_pixel (last_pixel),
    .offset     (offset)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      last_accepted <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      image_select  <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state         <= WRITE;
            last_accepted <= 1'b0;
          end
        end
        WRITE: begin
          // The writer always fills the image that is not on screen.
          if (accept) begin
            mem_we    <= 1'b1;
            mem_addr  <= (image_select ? BASE0 : BASE1) + offset;
            mem_wdata <= pix_data;
            if (last_pixel) last_accepted <= 1'b1;
          end else if (mem_ack) begin
            mem_we <= 1'b0;
          end
          if (last_accepted && mem_we && mem_ack) state <= WAIT_SWAP;
        end
        WAIT_SWAP: begin
          if (vblank) begin
            state        <= IDLE;
            image_select <= ~image_select;
            frame_done   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
